// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and constants for the ROM download path
// Contents:
//   dl_state_t   download controller states
//   ADDR_W       byte address width of the ioctl/ROM bus
//   REGION_BASE  EPROM region base addresses (also used by the address selector)
//   sat_inc      saturating increment for byte counters
package rom_dl_pkg;

    localparam int ADDR_W      = 25;
    localparam int NUM_REGIONS = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT_LO,
        EMIT_HI,
        HOLD,
        DONE
    } dl_state_t;

    localparam logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = '{
        25'h00000, 25'h08000, 25'h10000, 25'h12000, 25'h14000, 25'h16000, 25'h1E000,
        25'h26000, 25'h2E000, 25'h36000, 25'h3E000, 25'h46000, 25'h4E000, 25'h56000
    };

    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == '1) ? v : v + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dl_hold_timer.sv
// rtl/dl_hold_timer.sv - loadable down-counter with terminal-count pulse
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   load_i          reload count with load_val_i (has priority over en_i)
//   load_val_i      value to count down from; done fires load_val_i+1 enabled cycles after load
//   en_i            count enable
//   done_o          high while enabled and the count has reached zero
module dl_hold_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = en_i && !load_i && (count_q == '0);

endmodule

// File: rtl/rom_dl_ctrl.sv
// rtl/rom_dl_ctrl.sv - ioctl word stream to ROM byte writes, CPU reset hold
// Ports:
//   CLK_DL, RESET_N         clock, asynchronous active-low reset
//   IOCTL_DOWNLOAD/INDEX    host transfer active and image index
//   IOCTL_WR/ADDR/DOUT      16-bit word strobe, even byte address, data
//   IOCTL_WAIT              host back-pressure while a word is being split
//   ROM_WR/ADDR/DATA        byte write to selector and EPROM RAMs
//   CPU_RESET               hold for the game CPUs until the image is in
//   DL_DONE, DL_ERR         completion and sticky length/protocol error
//   BYTE_COUNT              bytes written in the current download
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int unsigned EXPECTED_BYTES = 'h5E000,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned ROM_INDEX      = 0
) (
    input  logic              CLK_DL,
    input  logic              RESET_N,
    input  logic              IOCTL_DOWNLOAD,
    input  logic [7:0]        IOCTL_INDEX,
    input  logic              IOCTL_WR,
    input  logic [ADDR_W-1:0] IOCTL_ADDR,
    input  logic [15:0]       IOCTL_DOUT,
    output logic              IOCTL_WAIT,
    output logic              ROM_WR,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [7:0]        ROM_DATA,
    output logic              CPU_RESET,
    output logic              DL_DONE,
    output logic              DL_ERR,
    output logic [ADDR_W-1:0] BYTE_COUNT
);

    localparam logic [7:0]        ROM_IDX   = 8'(ROM_INDEX);
    localparam logic [ADDR_W-1:0] EXP_CNT   = ADDR_W'(EXPECTED_BYTES);
    localparam logic [15:0]       HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    dl_state_t         state_q;
    logic              active_q;
    logic              end_q;      // download fell while a word was still being emitted
    logic [ADDR_W-1:0] addr_q;     // even address of the word in flight
    logic [7:0]        hi_q;       // high byte of the word in flight
    logic              hold_done;

    logic index_ok;
    logic active;
    logic active_rise;
    logic word_ok;

    assign index_ok    = (IOCTL_INDEX == ROM_IDX);
    assign active      = IOCTL_DOWNLOAD && index_ok;
    assign active_rise = active && !active_q;
    // A word strobed in the same cycle download drops still belongs to this image.
    assign word_ok     = IOCTL_WR && index_ok;

    // Timer is held loaded outside HOLD, so it starts counting on HOLD entry.
    dl_hold_timer #(
        .W (16)
    ) u_hold_timer (
        .clk_i      (CLK_DL),
        .rst_n_i    (RESET_N),
        .load_i     (state_q != HOLD),
        .load_val_i (HOLD_LOAD),
        .en_i       (state_q == HOLD),
        .done_o     (hold_done)
    );

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            active_q   <= 1'b0;
            end_q      <= 1'b0;
            addr_q     <= '0;
            hi_q       <= '0;
            IOCTL_WAIT <= 1'b0;
            ROM_WR     <= 1'b0;
            ROM_ADDR   <= '0;
            ROM_DATA   <= '0;
            CPU_RESET  <= 1'b1;
            DL_DONE    <= 1'b0;
            DL_ERR     <= 1'b0;
            BYTE_COUNT <= '0;
        end else begin
            active_q <= active;
            case (state_q)
                IDLE, DONE, HOLD: begin
                    if (active_rise) begin
                        state_q    <= LOAD;
                        end_q      <= 1'b0;
                        BYTE_COUNT <= '0;
                        DL_ERR     <= 1'b0;
                        DL_DONE    <= 1'b0;
                        CPU_RESET  <= 1'b1;
                    end else if (state_q == HOLD && hold_done) begin
                        state_q   <= DONE;
                        CPU_RESET <= 1'b0;
                        DL_DONE   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_ok) begin
                        addr_q     <= {IOCTL_ADDR[ADDR_W-1:1], 1'b0};
                        hi_q       <= IOCTL_DOUT[15:8];
                        end_q      <= !active;
                        DL_ERR     <= DL_ERR | IOCTL_ADDR[0];
                        IOCTL_WAIT <= 1'b1;
                        ROM_WR     <= 1'b1;
                        ROM_ADDR   <= {IOCTL_ADDR[ADDR_W-1:1], 1'b0};
                        ROM_DATA   <= IOCTL_DOUT[7:0];
                        BYTE_COUNT <= sat_inc(BYTE_COUNT);
                        state_q    <= EMIT_LO;
                    end else if (!active) begin
                        state_q <= HOLD;
                        DL_ERR  <= DL_ERR | (BYTE_COUNT != EXP_CNT);
                    end
                end
                EMIT_LO: begin
                    ROM_WR     <= 1'b1;
                    ROM_ADDR   <= {addr_q[ADDR_W-1:1], 1'b1};
                    ROM_DATA   <= hi_q;
                    BYTE_COUNT <= sat_inc(BYTE_COUNT);
                    end_q      <= end_q | !active;
                    DL_ERR     <= DL_ERR | word_ok;
                    state_q    <= EMIT_HI;
                end
                EMIT_HI: begin
                    ROM_WR     <= 1'b0;
                    IOCTL_WAIT <= 1'b0;
                    if (end_q || !active) begin
                        state_q <= HOLD;
                        DL_ERR  <= DL_ERR | word_ok | (BYTE_COUNT != EXP_CNT);
                    end else begin
                        state_q <= LOAD;
                        DL_ERR  <= DL_ERR | word_ok;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb/tb_rom_dl_ctrl.sv - self-checking bench for rom_dl_ctrl
module tb_rom_dl_ctrl;

    localparam int EXP_BYTES = 'h40;
    localparam int HOLD_CYC  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        rom_wr;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cpu_reset;
    logic        dl_done;
    logic        dl_err;
    logic [24:0] byte_count;

    rom_dl_ctrl #(
        .EXPECTED_BYTES (EXP_BYTES),
        .HOLD_CYCLES    (HOLD_CYC),
        .ROM_INDEX      (0)
    ) dut (
        .CLK_DL         (clk),
        .RESET_N        (rst_n),
        .IOCTL_DOWNLOAD (ioctl_download),
        .IOCTL_INDEX    (ioctl_index),
        .IOCTL_WR       (ioctl_wr),
        .IOCTL_ADDR     (ioctl_addr),
        .IOCTL_DOUT     (ioctl_dout),
        .IOCTL_WAIT     (ioctl_wait),
        .ROM_WR         (rom_wr),
        .ROM_ADDR       (rom_addr),
        .ROM_DATA       (rom_data),
        .CPU_RESET      (cpu_reset),
        .DL_DONE        (dl_done),
        .DL_ERR         (dl_err),
        .BYTE_COUNT     (byte_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected byte writes: each word issued at cycle N owes its low byte at N+1, high byte at N+2.
    typedef struct {
        int          at;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int      model_bytes = 0;

    always @(negedge clk) begin
        logic    want;
        exp_wr_t e;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            chk("missed_write", 32'(exp_q[0].addr), 32'h1FFFFFF);
            void'(exp_q.pop_front());
        end
        want = (exp_q.size() > 0) && (exp_q[0].at == cyc);
        chk("rom_wr", 32'(rom_wr), 32'(want));
        chk("ioctl_wait", 32'(ioctl_wait), 32'(want));
        if (want) begin
            e = exp_q.pop_front();
            model_bytes++;
            if (rom_wr) begin
                chk("rom_addr", 32'(rom_addr), 32'(e.addr));
                chk("rom_data", 32'(rom_data), 32'(e.data));
                chk("byte_count_run", 32'(byte_count), 32'(model_bytes));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ioctl_wait && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) chk("wait_bound", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic start_dl();
        tick();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        model_bytes    = 0;
        tick();
    endtask

    task automatic send_word(input logic [24:0] addr, input logic [15:0] data,
                             input bit push_hi, input bit drop, output int n);
        logic [24:0] a;
        wait_ready();
        a = addr;
        a[0] = 1'b0;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (drop) ioctl_download = 1'b0;
        n = cyc;
        exp_q.push_back('{at: cyc + 1, addr: a, data: data[7:0]});
        a[0] = 1'b1;
        if (push_hi) exp_q.push_back('{at: cyc + 2, addr: a, data: data[15:8]});
        tick();
    endtask

    // Hold lasts exactly HOLD_CYC cycles after the HOLD state is entered at cycle hold_at.
    task automatic check_hold(input int hold_at, input bit exp_err, input int exp_cnt);
        int guard = 0;
        while (cyc < hold_at + HOLD_CYC - 1 && guard < 100) begin
            tick();
            guard++;
        end
        chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("hold_dl_done", 32'(dl_done), 32'd0);
        tick();
        chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("done_dl_done", 32'(dl_done), 32'd1);
        chk("done_dl_err", 32'(dl_err), 32'(exp_err));
        chk("done_byte_count", 32'(byte_count), 32'(exp_cnt));
    endtask

    task automatic end_dl(input bit exp_err, input int exp_cnt);
        wait_ready();
        ioctl_download = 1'b0;
        check_hold(cyc + 1, exp_err, exp_cnt);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        chk({tag, "_rom_wr"}, 32'(rom_wr), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rom_data"}, 32'(rom_data), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_dl_done"}, 32'(dl_done), 32'd0);
        chk({tag, "_dl_err"}, 32'(dl_err), 32'd0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) tick();
        check_reset_vals("idle");

        // Single word, then a too-short image
        start_dl();
        send_word(25'h12000, 16'hA55A, 1'b1, 1'b0, n);
        chk("single_lo_wr", 32'(rom_wr), 32'd1);
        chk("single_lo_addr", 32'(rom_addr), 32'h12000);
        chk("single_lo_data", 32'(rom_data), 32'h5A);
        chk("single_lo_wait", 32'(ioctl_wait), 32'd1);
        tick();
        chk("single_hi_addr", 32'(rom_addr), 32'h12001);
        chk("single_hi_data", 32'(rom_data), 32'hA5);
        chk("single_hi_wait", 32'(ioctl_wait), 32'd1);
        chk("single_count", 32'(byte_count), 32'd2);
        tick();
        chk("single_wait_drop", 32'(ioctl_wait), 32'd0);
        end_dl(1'b1, 2);

        // Full image, back to back
        start_dl();
        chk("restart_err_clr", 32'(dl_err), 32'd0);
        chk("restart_done_clr", 32'(dl_done), 32'd0);
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_count_clr", 32'(byte_count), 32'd0);
        for (int i = 0; i < EXP_BYTES / 2; i++) begin
            send_word(25'(2 * i), {8'(i) ^ 8'h3C, 8'(i)}, 1'b1, 1'b0, n);
        end
        end_dl(1'b0, 'h40);

        // Other index: ignored, DONE state untouched
        tick();
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ioctl_addr = 25'(2 * i);
            ioctl_dout = 16'hDEAD;
            ioctl_wr   = 1'b1;
            tick();
        end
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        repeat (3) tick();
        chk("idx1_count", 32'(byte_count), 32'h40);
        chk("idx1_done", 32'(dl_done), 32'd1);
        chk("idx1_cpu_reset", 32'(cpu_reset), 32'd0);

        // Short image
        start_dl();
        for (int i = 0; i < 8; i++) begin
            send_word(25'h10000 + 25'(2 * i), 16'h1234 + 16'(i), 1'b1, 1'b0, n);
        end
        end_dl(1'b1, 'h10);

        // Protocol violations and same-cycle drop
        start_dl();
        chk("viol_err_clr", 32'(dl_err), 32'd0);
        send_word(25'h00000, 16'h1111, 1'b1, 1'b0, n);
        ioctl_addr = 25'h00040;
        ioctl_dout = 16'hBEEF;
        ioctl_wr   = 1'b1;
        tick();
        chk("viol_emit_err", 32'(dl_err), 32'd1);
        send_word(25'h00003, 16'hC3D4, 1'b1, 1'b0, n);
        tick();
        chk("odd_count", 32'(byte_count), 32'd4);
        send_word(25'h00004, 16'h5566, 1'b1, 1'b1, n);
        check_hold(n + 3, 1'b1, 6);

        // Reset between the two byte writes
        start_dl();
        send_word(25'h08000, 16'h7788, 1'b0, 1'b0, n);
        #6;
        rst_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick();
        rst_n = 1'b1;
        model_bytes = 0;
        repeat (3) tick();
        check_reset_vals("post_reset");

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
